muldiv_sequencer: RTL and testbench

Iterative RV32M multiply/divide controller attached to the execute stage. It latches operands when an M-extension instruction is in E and sequences a shared shift-add multiplier or restoring divider over 32 cycles. While it works it stalls the F/D/E pipeline, then presents the result for one cycle so the E→M pipeline register can capture it. Divide-by-zero and signed-overflow cases complete on a fast path.

---
 rtl/muldiv_sequencer.sv | 139 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer for the execute stage.
// Stalls F/D/E while a shift-add multiply or restoring divide runs.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            startE,
  input  logic [2:0]      funct3E,
  input  logic [XLEN-1:0] opAE,
  input  logic [XLEN-1:0] opBE,
  input  logic            flushE,
  output logic            stallE,
  output logic            busyE,
  output logic            doneE,
  output logic [XLEN-1:0] resultE
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MINNEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  logic [2:0]        fn;
  logic [CW-1:0]     count;
  logic [XLEN-1:0]   bReg;
  logic [2*XLEN-1:0] acc;
  logic              neg;

  logic            accept;
  logic            signedA, signedB;
  logic            negA, negB, negRes;
  logic [XLEN-1:0] magA, magB;
  logic            divZero, ovf, fast;
  logic [XLEN-1:0] fastRes;

  assign accept  = (state == IDLE) && startE && !flushE;
  assign stallE  = !rst && !flushE &&
                   (((state == IDLE) && startE) || (state == BUSY));
  assign busyE   = !rst && (state != IDLE);

  assign signedA = (funct3E == 3'b001) || (funct3E == 3'b010) ||
                   (funct3E == 3'b100) || (funct3E == 3'b110);
  assign signedB = (funct3E == 3'b001) || (funct3E == 3'b100) ||
                   (funct3E == 3'b110);
  assign negA    = signedA && opAE[XLEN-1];
  assign negB    = signedB && opBE[XLEN-1];
  assign magA    = negA ? -opAE : opAE;
  assign magB    = negB ? -opBE : opBE;
  // remainder takes the dividend's sign, everything else the xor
  assign negRes  = (funct3E[2] && funct3E[1]) ? negA : (negA ^ negB);

  assign divZero = funct3E[2] && (opBE == '0);
  assign ovf     = funct3E[2] && !funct3E[0] &&
                   (opAE == MINNEG) && (opBE == '1);
  assign fast    = divZero || ovf;
  assign fastRes = divZero ? (funct3E[1] ? opAE : '1)
                           : (funct3E[1] ? '0 : MINNEG);

  logic [XLEN:0]     addHi;
  logic [2*XLEN-1:0] mulNext;
  logic [XLEN:0]     remS, remN;
  logic              ge;
  logic [2*XLEN-1:0] divNext;
  logic [2*XLEN-1:0] accNext;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   word;
  logic [XLEN-1:0]   finalRes;

  always_comb begin
    addHi   = {1'b0, acc[2*XLEN-1:XLEN]} +
              (acc[0] ? {1'b0, bReg} : '0);
    mulNext = {addHi, acc[XLEN-1:1]};
    remS    = acc[2*XLEN-1:XLEN-1];
    ge      = remS >= {1'b0, bReg};
    remN    = ge ? remS - {1'b0, bReg} : remS;
    divNext = {remN[XLEN-1:0], acc[XLEN-2:0], ge};
    accNext = fn[2] ? divNext : mulNext;
    // a signed high word needs the full-width negation to get the borrow
    prod    = neg ? -accNext : accNext;
    word    = fn[1] ? accNext[2*XLEN-1:XLEN] : accNext[XLEN-1:0];
    if (fn[2])
      finalRes = neg ? -word : word;
    else if (fn[1:0] == 2'b00)
      finalRes = prod[XLEN-1:0];
    else
      finalRes = prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      fn      <= '0;
      count   <= '0;
      bReg    <= '0;
      acc     <= '0;
      neg     <= 1'b0;
      resultE <= '0;
      doneE   <= 1'b0;
    end else begin
      doneE <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            fn   <= funct3E;
            bReg <= magB;
            acc  <= {{XLEN{1'b0}}, magA};
            neg  <= negRes;
            if (fast) begin
              resultE <= fastRes;
              doneE   <= 1'b1;
              state   <= DONE;
            end else begin
              count <= CW'(XLEN - 1);
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (flushE) begin
            state <= IDLE;
          end else begin
            acc   <= accNext;
            count <= count - 1'b1;
            if (count == '0) begin
              resultE <= finalRes;
              doneE   <= 1'b1;
              state   <= DONE;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer.
// Checks results, done latency, stall counts, flush and reset.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        startE;
  logic [2:0]  funct3E;
  logic [31:0] opAE;
  logic [31:0] opBE;
  logic        flushE;
  logic        stallE;
  logic        busyE;
  logic        doneE;
  logic [31:0] resultE;

  int vectors = 0;
  int miscompares = 0;
  int cycNow = 0;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .startE  (startE),
    .funct3E (funct3E),
    .opAE    (opAE),
    .opBE    (opBE),
    .flushE  (flushE),
    .stallE  (stallE),
    .busyE   (busyE),
    .doneE   (doneE),
    .resultE (resultE)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycNow <= cycNow + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic runOp(input string tag,
                       input logic [2:0] f,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] exp,
                       input int expCyc,
                       output int doneAt);
    int cyc;
    int stalls;
    logic seen;
    @(posedge clk);
    #1;
    startE  = 1'b1;
    funct3E = f;
    opAE    = a;
    opBE    = b;
    cyc     = 1;
    stalls  = 0;
    seen    = 1'b0;
    #1;
    while (cyc <= 60) begin
      if (stallE) stalls++;
      if (doneE) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #2;
      cyc++;
    end
    startE = 1'b0;
    doneAt = cycNow;
    check({tag, " done"}, {31'b0, seen}, 32'd1);
    check({tag, " cycle"}, 32'(cyc), 32'(expCyc));
    check({tag, " stalls"}, 32'(stalls), 32'(expCyc - 1));
    check({tag, " result"}, resultE, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0;
    int t1;
    logic seenDone;
    rst     = 1'b0;
    startE  = 1'b0;
    funct3E = 3'b000;
    opAE    = '0;
    opBE    = '0;
    flushE  = 1'b0;
    #2 rst = 1'b1;
    #2;
    check("reset stall", {31'b0, stallE}, 32'd0);
    check("reset busy", {31'b0, busyE}, 32'd0);
    check("reset done", {31'b0, doneE}, 32'd0);
    check("reset result", resultE, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    runOp("MUL 7*-3", 3'b000, 32'd7, 32'hFFFF_FFFD,
          32'hFFFF_FFEB, 34, t0);
    runOp("MULHU max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'hFFFF_FFFE, 34, t0);
    runOp("MULH min", 3'b001, 32'h8000_0000, 32'h8000_0000,
          32'h4000_0000, 34, t0);
    runOp("MULHSU -1", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'hFFFF_FFFF, 34, t0);
    runOp("MULH -1*1", 3'b001, 32'hFFFF_FFFF, 32'd1,
          32'hFFFF_FFFF, 34, t0);
    runOp("DIV -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2,
          32'hFFFF_FFFD, 34, t0);
    runOp("REM -7/2", 3'b110, 32'hFFFF_FFF9, 32'd2,
          32'hFFFF_FFFF, 34, t0);
    runOp("DIVU 100/7", 3'b101, 32'd100, 32'd7,
          32'd14, 34, t0);
    runOp("REMU 100/7", 3'b111, 32'd100, 32'd7,
          32'd2, 34, t0);
    runOp("DIV min/1", 3'b100, 32'h8000_0000, 32'd1,
          32'h8000_0000, 34, t0);
    runOp("DIVU 5/0", 3'b101, 32'd5, 32'd0,
          32'hFFFF_FFFF, 2, t0);
    runOp("REM x/0", 3'b110, 32'hFFFF_FFF9, 32'd0,
          32'hFFFF_FFF9, 2, t0);
    runOp("DIV ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF,
          32'h8000_0000, 2, t0);
    runOp("REM ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF,
          32'h0000_0000, 2, t0);

    runOp("B2B DIVU 9/3", 3'b101, 32'd9, 32'd3, 32'd3, 34, t0);
    runOp("B2B MUL 5*5", 3'b000, 32'd5, 32'd5, 32'd25, 34, t1);
    check("B2B spacing", 32'(t1 - t0), 32'd34);

    // flush while BUSY at counter 10 (cycle 23 in E)
    @(posedge clk);
    #1;
    startE  = 1'b1;
    funct3E = 3'b000;
    opAE    = 32'd9;
    opBE    = 32'd9;
    repeat (22) @(posedge clk);
    #1 flushE = 1'b1;
    #1;
    check("flush stall", {31'b0, stallE}, 32'd0);
    check("flush busy", {31'b0, busyE}, 32'd1);
    @(posedge clk);
    #1;
    flushE = 1'b0;
    startE = 1'b0;
    #1;
    check("post-flush busy", {31'b0, busyE}, 32'd0);
    check("post-flush done", {31'b0, doneE}, 32'd0);
    seenDone = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 seenDone = seenDone | doneE;
    end
    check("flush no done", {31'b0, seenDone}, 32'd0);
    check("flush keeps result", resultE, 32'd25);
    runOp("MUL 3*4", 3'b000, 32'd3, 32'd4, 32'd12, 34, t0);

    // start together with flush in IDLE is not accepted
    @(posedge clk);
    #1;
    startE = 1'b1;
    flushE = 1'b1;
    #1;
    check("idle flush stall", {31'b0, stallE}, 32'd0);
    @(posedge clk);
    #1;
    startE = 1'b0;
    flushE = 1'b0;
    #1;
    check("idle flush busy", {31'b0, busyE}, 32'd0);

    // asynchronous reset in the middle of BUSY
    @(posedge clk);
    #1;
    startE  = 1'b1;
    funct3E = 3'b101;
    opAE    = 32'd1000;
    opBE    = 32'd3;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst stall", {31'b0, stallE}, 32'd0);
    check("midrst busy", {31'b0, busyE}, 32'd0);
    check("midrst done", {31'b0, doneE}, 32'd0);
    check("midrst result", resultE, 32'd0);
    startE = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    runOp("after rst DIVU", 3'b101, 32'd1000, 32'd3,
          32'd333, 34, t0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
